// File: rtl/seq_1101.sv
// Moore detector for the serial pattern 1-1-0-1 with overlap; out is a
// one-cycle flag decoded purely from the state register.
module seq_1101 (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // S4 falls back to S2 on a 1 because its trailing 1 plus the new 1 form "11".
  always_comb begin
    state_next = S0;
    case (state)
      S0:      state_next = in ? S1 : S0;
      S1:      state_next = in ? S2 : S0;
      S2:      state_next = in ? S2 : S3;
      S3:      state_next = in ? S4 : S0;
      S4:      state_next = in ? S2 : S0;
      default: state_next = S0;
    endcase
  end

  assign out = (state == S4);

endmodule

// File: tb/tb_seq_1101.sv
// Self-checking bench for seq_1101: a sliding-window model of the last four
// bits since reset, directed pattern tables, then randomized traffic.
module tb_seq_1101;

  logic clk;
  logic reset;
  logic din;
  logic out;

  // Reference model: bit history since the last reset edge.
  logic [3:0] hist;
  int         nbits;
  bit         model_known;
  logic       exp_out;

  // Literal pins requested by the stimulus process, consumed by the checker.
  int         pin_req;
  int         pin_done;
  logic       pin_value;
  string      pin_name;

  int         vectors;
  int         miscompares;

  seq_1101 dut (
    .clk  (clk),
    .reset(reset),
    .in   (din),
    .out  (out)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Drive one bit (or a reset) across one rising edge and advance the model.
  task automatic applyStimulus(input logic r, input logic b);
    reset = r;
    din   = b;
    @(posedge clk);
    if (r) begin
      nbits       = 0;
      hist        = 4'b0000;
      model_known = 1'b1;
    end else begin
      hist  = {hist[2:0], b};
      nbits = nbits + 1;
    end
    exp_out = model_known && (nbits >= 4) && (hist == 4'b1101);
    #20;
  endtask

  // Request a literal check of out against a hand-computed value.
  task automatic checkOutput(input string name, input logic value);
    pin_name  = name;
    pin_value = value;
    pin_req   = pin_req + 1;
  endtask

  // Feed n bits (first bit at position n-1) and pin each cycle's out.
  task automatic runSeq(input string name, input logic [15:0] bits,
                        input logic [15:0] expect_bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b0, bits[i]);
      checkOutput($sformatf("%s_bit%0d", name, n - 1 - i), expect_bits[i]);
    end
  endtask

  // Single compare process: model check every cycle, plus any pending pin.
  always @(negedge clk) begin
    if (model_known) begin
      vectors = vectors + 1;
      if (out !== exp_out) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL model_check t=%0t out=%b expected=%b", $time, out, exp_out);
      end
    end
    if (pin_req != pin_done) begin
      pin_done = pin_req;
      vectors  = vectors + 1;
      if (out !== pin_value || exp_out !== pin_value) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s t=%0t out=%b model=%b expected=%b",
                 pin_name, $time, out, exp_out, pin_value);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    din         = 1'b0;
    hist        = 4'b0000;
    nbits       = 0;
    model_known = 1'b0;
    exp_out     = 1'b0;
    pin_req     = 0;
    pin_done    = 0;
    pin_value   = 1'b0;
    pin_name    = "";
    vectors     = 0;
    miscompares = 0;

    // Reset held across edges with in toggling, then idle zeros.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_out", 1'b0);
    runSeq("idle", 16'b0000, 16'b0000, 4);

    // Basic detect, overlap, extra-1 hold.
    runSeq("detect",  16'b01101,     16'b00001,     5);
    runSeq("overlap", 16'b101,       16'b001,       3);
    runSeq("hold",    16'b011101010, 16'b000001000, 9);

    // Near misses.
    runSeq("near_a", 16'b10011001, 16'b00000000, 8);
    runSeq("near_b", 16'b1111,     16'b0000,     4);

    // Reset mid-pattern discards the partial match.
    runSeq("pre_rst", 16'b110, 16'b000, 3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_reset", 1'b0);
    runSeq("post_rst", 16'b1, 16'b0, 1);
    runSeq("after_rst", 16'b1101, 16'b0001, 4);

    // Randomized traffic with sparse resets, biased toward 1s to hit 1101 often.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
